pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
Sequences the program counter for the fetch stage of the RISC-V core: owns the PC register and presents fetch requests to instruction memory over a req/ready handshake. Applies sequential increment, redirects (taken branch / JAL / JALR from execute) and hazard-unit stalls. Drives a flush pulse to the IF/ID register. It has a one-entry hold buffer so a fetch that completes during a stall is not lost.

Parameters:
DATA_WIDTH, 32, width of PC, target and instruction words
RESET_PC, 32'h0000_0000, PC value loaded on reset
OFFSET, 4, sequential PC increment in bytes

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold the fetch output this cycle
redirect_valid  in  1  execute stage: redirect to redirect_target
redirect_target  in  DATA_WIDTH  branch/jump target (PC+ImmOp or rs1+imm)
imem_req  out  1  fetch request
imem_addr  out  DATA_WIDTH  fetch address; stable while imem_req && !imem_ready
imem_ready  in  1  memory accepts request; imem_rdata valid same cycle
imem_rdata  in  DATA_WIDTH  fetched instruction
if_valid  out  1  instruction/PC pair valid to IF/ID
if_pc  out  DATA_WIDTH  PC of presented instruction
if_instr  out  DATA_WIDTH  presented instruction
flush  out  1  clear IF/ID (equals redirect_valid, combinational)
misalign  out  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Reset (sync, priority over all inputs): state=BOOT, pc=RESET_PC, hold buffer empty, pending_pc=0. imem_req=0 and if_valid=0 from the next edge. Reset mid-handshake abandons the request.
- The target used everywhere is {redirect_target[DW-1:2],2'b00}. misalign pulses in the cycle of the redirect. PC arithmetic wraps modulo 2^DATA_WIDTH.
- Redirect beats stall. flush=redirect_valid in every state, including BOOT.
- States:
- BOOT: imem_req=0. Next state is FETCH. If a redirect arrives, pc<=target.
- FETCH: imem_req=1, imem_addr=pc.
  - redirect && imem_ready: returned word is discarded; pc<=target; stay in FETCH.
  - redirect && !imem_ready: pending_pc<=target; go to KILL. Address is held.
  - no redirect, imem_ready, !stall: if_valid=1, if_pc=pc, if_instr=imem_rdata (same cycle, zero latency). pc<=pc+OFFSET.
  - no redirect, imem_ready, stall: buffer<={pc,imem_rdata}; pc<=pc+OFFSET; go to HOLD.
  - !imem_ready: no change.
- KILL: imem_req=1, imem_addr=stale pc (handshake must not be withdrawn); if_valid=0.
  - On imem_ready: data is discarded; pc<=pending_pc; go to FETCH.
  - A further redirect overwrites pending_pc. If it coincides with ready, the newest target wins.
- HOLD: imem_req=0; if_valid=!stall with if_pc/if_instr taken from the buffer.
  - !stall: buffer emptied; go to FETCH.
  - redirect: buffer dropped, if_valid=0, pc<=target; go to FETCH.
- if_valid is never asserted in BOOT or KILL, or in any cycle with redirect_valid=1.
- Throughput is 1 instruction/cycle with imem_ready held high and no stall.
- if_pc/if_instr are don't-care when if_valid=0. They are driven 0 in BOOT.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum fetch_state_t {BOOT, FETCH, KILL, HOLD};
  - the default RESET_PC constant;
  - the ALIGN_MASK constant.
- One natural sub-module, pc_hold_buffer: a one-entry {pc,instr} register with load/clear/valid. The FSM and PC register stay in the top.

Test Plan:
- Reset release with imem_ready=1 and no stall → BOOT one cycle, then addresses 0x0, 0x4, 0x8. if_valid=1 each cycle with if_pc matching the address.
- Redirect to 0x100 while in FETCH with imem_ready=1 at pc=0x8 → flush=1, if_valid=0, next imem_addr=0x100, then 0x104.
- imem_ready=0 at pc=0x10, redirect to 0x200, ready returns 3 cycles later → imem_addr stays 0x10 through KILL, data is discarded, then imem_addr=0x200. A second redirect to 0x300 during KILL means 0x300 is fetched instead.
- Fetch of 0x20 completes with stall=1 held 2 cycles → imem_req=0 and if_valid=0 during stall. On release, if_valid=1 with if_pc=0x20 and the buffered instr, then a fetch of 0x24.
- Redirect to 0x402 → misalign pulses for 1 cycle and the fetch is issued at 0x400.
- rst asserted mid-KILL → next cycle imem_req=0 and if_valid=0, pc=RESET_PC. The first fetch after BOOT is at 0x0, with no stale pending redirect.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        KILL,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Low address bits that must be zero for a word-aligned instruction fetch.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] i_lsbs);
        return |(i_lsbs & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory handshake, IF/ID output.
interface pc_fetch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  stall;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_pc;
    logic [DATA_WIDTH-1:0] if_instr;
    logic                  flush;
    logic                  misalign;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  imem_ready,
        input  imem_rdata,
        output imem_req,
        output imem_addr,
        output if_valid,
        output if_pc,
        output if_instr,
        output flush,
        output misalign
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_target,
        output imem_ready,
        output imem_rdata,
        input  imem_req,
        input  imem_addr,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        input  flush,
        input  misalign
    );

endinterface

// File: rtl/pc_hold_buffer.sv
// One-entry {pc, instr} buffer catching a fetch that completes while the pipeline is stalled.
module pc_hold_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_instr,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_instr
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, drives the imem req/ready handshake,
// applies redirects and stalls, and presents instruction/PC pairs to IF/ID.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned          OFFSET     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pc_fetch_sequencer_if.master io_bus
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] r_pending_pc;
    logic [DATA_WIDTH-1:0] w_pending_next;

    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic                  w_buf_load;
    logic                  w_buf_clear;
    logic                  w_buf_valid;
    logic [DATA_WIDTH-1:0] w_buf_pc;
    logic [DATA_WIDTH-1:0] w_buf_instr;

    logic                  w_imem_req;
    logic                  w_if_valid;
    logic [DATA_WIDTH-1:0] w_if_pc;
    logic [DATA_WIDTH-1:0] w_if_instr;

    assign w_target = {io_bus.redirect_target[DATA_WIDTH-1:2],
                       io_bus.redirect_target[1:0] & ~ALIGN_MASK};
    assign w_pc_inc = r_pc + DATA_WIDTH'(OFFSET);

    pc_hold_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold_buffer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_pc    (r_pc),
        .i_instr (io_bus.imem_rdata),
        .o_valid (w_buf_valid),
        .o_pc    (w_buf_pc),
        .o_instr (w_buf_instr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_pending_pc <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_pending_pc <= w_pending_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_pending_next = r_pending_pc;
        w_buf_load     = 1'b0;
        w_buf_clear    = 1'b0;
        w_imem_req     = 1'b0;
        w_if_valid     = 1'b0;
        w_if_pc        = '0;
        w_if_instr     = '0;

        case (r_state)
            BOOT: begin
                w_state_next = FETCH;
                if (io_bus.redirect_valid) begin
                    w_pc_next = w_target;
                end
            end

            FETCH: begin
                w_imem_req = 1'b1;
                if (io_bus.redirect_valid) begin
                    if (io_bus.imem_ready) begin
                        w_pc_next = w_target;
                    end else begin
                        // Request already on the bus: it must complete before we can retarget.
                        w_pending_next = w_target;
                        w_state_next   = KILL;
                    end
                end else if (io_bus.imem_ready) begin
                    w_pc_next = w_pc_inc;
                    if (io_bus.stall) begin
                        w_buf_load   = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_if_valid = 1'b1;
                        w_if_pc    = r_pc;
                        w_if_instr = io_bus.imem_rdata;
                    end
                end
            end

            KILL: begin
                w_imem_req = 1'b1;
                if (io_bus.imem_ready) begin
                    w_pc_next    = io_bus.redirect_valid ? w_target : r_pending_pc;
                    w_state_next = FETCH;
                end else if (io_bus.redirect_valid) begin
                    w_pending_next = w_target;
                end
            end

            HOLD: begin
                if (io_bus.redirect_valid) begin
                    w_buf_clear  = 1'b1;
                    w_pc_next    = w_target;
                    w_state_next = FETCH;
                end else if (!io_bus.stall) begin
                    w_if_valid   = w_buf_valid;
                    w_if_pc      = w_buf_pc;
                    w_if_instr   = w_buf_instr;
                    w_buf_clear  = 1'b1;
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    assign io_bus.imem_req  = w_imem_req;
    assign io_bus.imem_addr = r_pc;
    assign io_bus.if_valid  = w_if_valid;
    assign io_bus.if_pc     = w_if_pc;
    assign io_bus.if_instr  = w_if_instr;
    assign io_bus.flush     = io_bus.redirect_valid;
    assign io_bus.misalign  = io_bus.redirect_valid && is_misaligned(io_bus.redirect_target[1:0]);

endmodule
